key_repeat_ctrl: RTL and testbench

Keyboard command stage between the SoC `keycode` PIO and `Game_Logic`. It turns the raw USB HID keycode into at most one Tetris move command per video frame, with delayed auto-shift (DAS) and auto-repeat. Its command register is stable for a whole frame, so `Game_Logic`, clocked on `~VGA_VS`, samples it without a clock-domain race.

---
 rtl/tetris_pkg.sv | 43 ++++
 rtl/key_repeat_ctrl_vs_edge_sync.sv | 27 ++
 rtl/key_repeat_ctrl.sv | 103 ++++++++++
 tb/tb_key_repeat_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris types: move commands, keycode constants, repeat FSM states
// and the keycode-to-command decoder.
package tetris_pkg;

    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_LEFT   = 3'd1,
        CMD_RIGHT  = 3'd2,
        CMD_ROTATE = 3'd3,
        CMD_SOFT   = 3'd4,
        CMD_HARD   = 3'd5
    } cmd_t;

    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_SPACE = 8'h2C;
    localparam logic [7:0] KC_RIGHT = 8'h4F;
    localparam logic [7:0] KC_LEFT  = 8'h50;
    localparam logic [7:0] KC_DOWN  = 8'h51;
    localparam logic [7:0] KC_UP    = 8'h52;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_DELAY  = 2'd1;
    localparam state_t ST_REPEAT = 2'd2;
    localparam state_t ST_HOLD   = 2'd3;

    function automatic cmd_t decode_key(input logic [7:0] kc);
        cmd_t c;
        case (kc)
            KC_A, KC_LEFT:  c = CMD_LEFT;
            KC_D, KC_RIGHT: c = CMD_RIGHT;
            KC_W, KC_UP:    c = CMD_ROTATE;
            KC_S, KC_DOWN:  c = CMD_SOFT;
            KC_SPACE:       c = CMD_HARD;
            default:        c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/key_repeat_ctrl_vs_edge_sync.sv
// Brings VGA vsync into the Clk domain and strobes frame_tick for one cycle
// on each falling edge (start of vertical sync).
module vs_edge_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic vs,
    output logic frame_tick
);

    logic sync1, sync2, prev;

    // All flops reset high so releasing Reset never looks like a falling edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= vs;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign frame_tick = prev & ~sync2;

endmodule

// File: rtl/key_repeat_ctrl.sv
// Turns the raw HID keycode into at most one move command per frame, with
// delayed auto-shift and auto-repeat for left/right and soft drop.
module key_repeat_ctrl
    import tetris_pkg::*;
#(
    parameter int DAS_FRAMES  = 10,
    parameter int ARR_FRAMES  = 3,
    parameter int SOFT_FRAMES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic       vs,
    output cmd_t       cmd_pulse,
    output cmd_t       cmd_frame,
    output logic       frame_tick
);

    localparam logic [5:0] DAS  = DAS_FRAMES[5:0];
    localparam logic [5:0] ARR  = ARR_FRAMES[5:0];
    localparam logic [5:0] SOFT = SOFT_FRAMES[5:0];

    logic [7:0] keycode_q;
    state_t     state, state_nxt;
    cmd_t       held, held_nxt, act;
    logic [5:0] cnt, cnt_nxt, cnt_inc, period;
    logic       emit;

    vs_edge_sync u_vs_sync (
        .Clk        (Clk),
        .Reset      (Reset),
        .vs         (vs),
        .frame_tick (frame_tick)
    );

    assign act     = decode_key(keycode_q);
    assign cnt_inc = (cnt == 6'd63) ? cnt : cnt + 6'd1;
    assign period  = (held == CMD_SOFT) ? SOFT : ARR;

    // Next-state evaluation; only committed on a frame tick.
    always_comb begin
        state_nxt = state;
        held_nxt  = held;
        cnt_nxt   = cnt;
        emit      = 1'b0;
        if (act == CMD_NONE) begin
            state_nxt = ST_IDLE;
            held_nxt  = CMD_NONE;
            cnt_nxt   = 6'd0;
        end else if (act != held) begin
            emit     = 1'b1;
            held_nxt = act;
            cnt_nxt  = 6'd0;
            case (act)
                CMD_LEFT, CMD_RIGHT: state_nxt = ST_DELAY;
                CMD_SOFT:            state_nxt = ST_REPEAT;
                default:             state_nxt = ST_HOLD;
            endcase
        end else begin
            case (state)
                ST_DELAY: begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == DAS) begin
                        emit      = 1'b1;
                        cnt_nxt   = 6'd0;
                        state_nxt = ST_REPEAT;
                    end
                end
                ST_REPEAT: begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == period) begin
                        emit    = 1'b1;
                        cnt_nxt = 6'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            keycode_q <= 8'h00;
            state     <= ST_IDLE;
            held      <= CMD_NONE;
            cnt       <= 6'd0;
            cmd_pulse <= CMD_NONE;
            cmd_frame <= CMD_NONE;
        end else begin
            keycode_q <= keycode;
            if (frame_tick) begin
                state     <= state_nxt;
                held      <= held_nxt;
                cnt       <= cnt_nxt;
                cmd_pulse <= emit ? act : CMD_NONE;
                cmd_frame <= emit ? act : CMD_NONE;
            end else begin
                cmd_pulse <= CMD_NONE;
            end
        end
    end

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Directed bench for key_repeat_ctrl: drives vsync frames and keycodes and
// compares every tick's command against hand-computed expectations.
module tb_key_repeat_ctrl;
    import tetris_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] keycode;
    logic       vs;
    cmd_t       cmd_pulse, cmd_frame;
    logic       frame_tick;

    int n_tests = 0;
    int n_fail  = 0;
    int tick_cnt = 0;

    key_repeat_ctrl #(.DAS_FRAMES(10), .ARR_FRAMES(3), .SOFT_FRAMES(2)) dut (
        .Clk        (clk),
        .Reset      (rst),
        .keycode    (keycode),
        .vs         (vs),
        .cmd_pulse  (cmd_pulse),
        .cmd_frame  (cmd_frame),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_tick) tick_cnt <= tick_cnt + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame: vs sampled low at edge E, tick after E+1, command after E+2.
    task automatic frame(input cmd_t exp, input string tag);
        @(posedge clk); #1 vs = 1'b0;
        @(posedge clk); #1 check({tag, "_tick_early"}, int'(frame_tick), 0);
        @(posedge clk); #1 check({tag, "_tick"}, int'(frame_tick), 1);
        check({tag, "_pulse_early"}, int'(cmd_pulse), int'(CMD_NONE));
        @(posedge clk); #1 check({tag, "_pulse"}, int'(cmd_pulse), int'(exp));
        check({tag, "_frame"}, int'(cmd_frame), int'(exp));
        check({tag, "_tick_off"}, int'(frame_tick), 0);
        @(posedge clk); #1 check({tag, "_pulse_clr"}, int'(cmd_pulse), int'(CMD_NONE));
        check({tag, "_frame_hold"}, int'(cmd_frame), int'(exp));
        vs = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic set_key(input logic [7:0] kc);
        @(posedge clk); #1 keycode = kc;
    endtask

    initial begin
        int c0;
        cmd_t e;
        rst = 1'b1; vs = 1'b1; keycode = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pulse", int'(cmd_pulse), int'(CMD_NONE));
        check("rst_frame", int'(cmd_frame), int'(CMD_NONE));
        check("rst_tick",  int'(frame_tick), 0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        check("rel_no_tick", tick_cnt, 0);

        // LEFT with DAS then ARR repeats
        set_key(8'h04);
        for (int i = 0; i < 20; i++) begin
            e = (i == 0 || i == 10 || i == 13 || i == 16 || i == 19) ? CMD_LEFT : CMD_NONE;
            frame(e, $sformatf("left%0d", i));
        end
        set_key(8'h00);
        frame(CMD_NONE, "left_rel");

        // Soft drop repeats every 2 frames
        set_key(8'h51);
        for (int i = 0; i < 7; i++) begin
            e = (i % 2 == 0) ? CMD_SOFT : CMD_NONE;
            frame(e, $sformatf("soft%0d", i));
        end
        // Reset while a command is held, key kept down -> fresh press after
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 check("soft_rst_frame", int'(cmd_frame), int'(CMD_NONE));
        check("soft_rst_pulse", int'(cmd_pulse), int'(CMD_NONE));
        rst = 1'b0;
        repeat (3) @(posedge clk);
        frame(CMD_SOFT, "soft_repress");
        set_key(8'h00);
        frame(CMD_NONE, "soft_rel");

        // Rotate never repeats; release and re-press re-emits
        set_key(8'h1A);
        for (int i = 0; i < 30; i++) begin
            e = (i == 0) ? CMD_ROTATE : CMD_NONE;
            frame(e, $sformatf("rot%0d", i));
        end
        set_key(8'h00);
        frame(CMD_NONE, "rot_rel");
        set_key(8'h1A);
        frame(CMD_ROTATE, "rot_again");
        frame(CMD_NONE, "rot_again1");
        set_key(8'h00);
        frame(CMD_NONE, "rot_rel2");

        // RIGHT then switch to LEFT arrow: new press, DAS restarts
        set_key(8'h07);
        for (int i = 0; i < 5; i++) begin
            e = (i == 0) ? CMD_RIGHT : CMD_NONE;
            frame(e, $sformatf("sw%0d", i));
        end
        set_key(8'h50);
        for (int i = 5; i < 16; i++) begin
            e = (i == 5 || i == 15) ? CMD_LEFT : CMD_NONE;
            frame(e, $sformatf("sw%0d", i));
        end
        set_key(8'h00);
        frame(CMD_NONE, "sw_rel");

        // Hard drop, reset at tick 5 overlapping a vs falling edge
        set_key(8'h2C);
        for (int i = 0; i < 5; i++) begin
            e = (i == 0) ? CMD_HARD : CMD_NONE;
            frame(e, $sformatf("hard%0d", i));
        end
        @(posedge clk); #1 vs = 1'b0; rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("hrst%0d_tick", i), int'(frame_tick), 0);
            check($sformatf("hrst%0d_pulse", i), int'(cmd_pulse), int'(CMD_NONE));
            check($sformatf("hrst%0d_frame", i), int'(cmd_frame), int'(CMD_NONE));
        end
        rst = 1'b0;
        @(posedge clk); #1 check("hrst_tick_early", int'(frame_tick), 0);
        @(posedge clk); #1 check("hrst_tick", int'(frame_tick), 1);
        @(posedge clk); #1 check("hrst_pulse", int'(cmd_pulse), int'(CMD_HARD));
        check("hrst_frame", int'(cmd_frame), int'(CMD_HARD));
        vs = 1'b1;
        repeat (3) @(posedge clk);
        for (int i = 1; i < 5; i++) frame(CMD_NONE, $sformatf("hard_post%0d", i));
        set_key(8'h00);
        frame(CMD_NONE, "hard_rel");

        // Right arrow latency, then long-low vsync gives one tick per edge
        set_key(8'h4F);
        frame(CMD_RIGHT, "rarrow");
        set_key(8'h00);
        frame(CMD_NONE, "rarrow_rel");
        c0 = tick_cnt;
        for (int f = 0; f < 3; f++) begin
            @(posedge clk); #1 vs = 1'b0;
            repeat (20) @(posedge clk);
            #1 vs = 1'b1;
            repeat (5) @(posedge clk);
        end
        #1 check("long_low_ticks", tick_cnt - c0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
